// File: rtl/uart_pkg.sv
// Shared UART definitions: 8N1 frame constants and FSM state encodings.
package uart_pkg;

  localparam int unsigned DataBits = 8;
  localparam int unsigned StopBits = 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/baud_cnt.sv
// Bit-period counter: counts 0..DIV-1 while enabled and wraps to 0.
module baud_cnt #(
  parameter int unsigned DIV  = 434,
  parameter int unsigned DIVW = 9
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            en_i,
  output logic [DIVW-1:0] cnt_o
);

  localparam logic [DIVW-1:0] LastCnt = DIVW'(DIV - 1);

  logic [DIVW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + DIVW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes RXD, samples mid-bit, reports good bytes or framing errors.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DIV  = 434,
  parameter int unsigned DIVW = 9
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXD,
  output logic [7:0] DATA,
  output logic       VALID,
  output logic       FERR,
  output logic       BUSY
);

  localparam logic [DIVW-1:0] HalfCnt = DIVW'(DIV / 2 - 1);
  localparam logic [DIVW-1:0] LastCnt = DIVW'(DIV - 1);
  localparam logic [2:0]      LastIdx = 3'(DataBits - 1);

  uart_state_e         state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [DataBits-1:0] shift_q, shift_d;
  logic [7:0]          data_q, data_d;
  logic                valid_q, valid_d;
  logic                ferr_q, ferr_d;
  logic                sync1_q, sync2_q, hist_q;
  logic [DIVW-1:0]     cnt;
  logic                cnt_clr;

  baud_cnt #(
    .DIV  (DIV),
    .DIVW (DIVW)
  ) u_baud_cnt (
    .clk_i  (CLK),
    .rst_ni (RST),
    .clr_i  (cnt_clr),
    .en_i   (state_q != StIdle),
    .cnt_o  (cnt)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    cnt_clr = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Only a high-to-low transition starts a frame; a line stuck low never does.
        if (hist_q && !sync2_q) begin
          cnt_clr = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt == HalfCnt) begin
          if (sync2_q) begin
            state_d = StIdle;
          end else begin
            cnt_clr = 1'b1;
            idx_d   = '0;
            state_d = StData;
          end
        end
      end
      StData: begin
        if (cnt == LastCnt) begin
          shift_d = {sync2_q, shift_q[DataBits-1:1]};
          cnt_clr = 1'b1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == LastIdx) begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        if (cnt == LastCnt) begin
          cnt_clr = 1'b1;
          state_d = StIdle;
          if (sync2_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      sync1_q <= RXD;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign DATA  = data_q;
  assign VALID = valid_q;
  assign FERR  = ferr_q;
  assign BUSY  = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames on a DIV=16 instance and a DIV=434 instance.
module tb_uart_rx;

  localparam int Div     = 16;
  localparam int DivFast = 434;
  localparam int LatExp  = Div * 19 / 2 + 3;

  typedef struct {
    logic       is_ferr;
    logic [7:0] data;
    int         t_fall;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxd = 1'b1;
  logic       rxd_f = 1'b1;
  logic [7:0] data, data_f;
  logic       valid, ferr, busy;
  logic       valid_f, ferr_f, busy_f;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_valid = 0, n_ferr = 0, n_valid_f = 0;
  exp_t q[$];
  exp_t qf[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(
    .DIV  (Div),
    .DIVW (5)
  ) dut (
    .CLK   (clk),
    .RST   (rst),
    .RXD   (rxd),
    .DATA  (data),
    .VALID (valid),
    .FERR  (ferr),
    .BUSY  (busy)
  );

  uart_rx #(
    .DIV  (DivFast),
    .DIVW (9)
  ) dut_fast (
    .CLK   (clk),
    .RST   (rst),
    .RXD   (rxd_f),
    .DATA  (data_f),
    .VALID (valid_f),
    .FERR  (ferr_f),
    .BUSY  (busy_f)
  );

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fast, input logic v);
    if (fast) rxd_f = v;
    else rxd = v;
  endtask

  task automatic frame(input logic fast, input logic [7:0] b, input logic stop, input int period);
    drive(fast, 1'b0);
    wait_cyc(period);
    for (int i = 0; i < 8; i++) begin
      drive(fast, b[i]);
      wait_cyc(period);
    end
    drive(fast, stop);
    wait_cyc(period);
  endtask

  // Monitor for the DIV=16 instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst && (valid || ferr)) begin
      if (valid) n_valid++;
      if (ferr) n_ferr++;
      chk("valid_ferr_exclusive", int'(valid && ferr), 0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: valid=%0b ferr=%0b data=0x%0h, none expected",
                 valid, ferr, data);
      end else begin
        e = q.pop_front();
        chk("event_is_ferr", int'(ferr), int'(e.is_ferr));
        chk("event_data", int'(data), int'(e.data));
        if (e.t_fall >= 0) chk_rng("valid_latency", cyc - e.t_fall, LatExp - 1, LatExp + 1);
      end
    end
  end

  // Monitor for the DIV=434 instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst && (valid_f || ferr_f)) begin
      if (valid_f) n_valid_f++;
      if (qf.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event_fast: valid=%0b ferr=%0b data=0x%0h, none expected",
                 valid_f, ferr_f, data_f);
      end else begin
        e = qf.pop_front();
        chk("fast_is_ferr", int'(ferr_f), int'(e.is_ferr));
        chk("fast_data", int'(data_f), int'(e.data));
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_cnt;
    wait_cyc(3);
    chk("reset_data", int'(data), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_ferr", int'(ferr), 0);
    chk("reset_busy", int'(busy), 0);
    rst = 1'b1;
    wait_cyc(4);

    // Good frame with latency measurement.
    q.push_back('{1'b0, 8'hA5, cyc});
    frame(1'b0, 8'hA5, 1'b1, Div);
    wait_cyc(2 * Div);

    // Stop bit low, then line held low: no new frame may start.
    q.push_back('{1'b1, 8'hA5, -1});
    frame(1'b0, 8'h3C, 1'b0, Div);
    wait_cyc(3 * Div);
    chk("low_line_no_start", int'(busy), 0);
    rxd = 1'b1;
    wait_cyc(2 * Div);
    q.push_back('{1'b0, 8'h5A, -1});
    frame(1'b0, 8'h5A, 1'b1, Div);
    wait_cyc(2 * Div);

    // Short low glitch is rejected.
    busy_cnt = 0;
    rxd = 1'b0;
    for (int i = 0; i < 44; i++) begin
      wait_cyc(1);
      if (i == 3) rxd = 1'b1;
      if (busy) busy_cnt++;
    end
    chk_rng("glitch_busy_cycles", busy_cnt, 1, Div / 2 + 3);
    chk("glitch_back_idle", int'(busy), 0);

    // Back-to-back frames with no idle gap.
    q.push_back('{1'b0, 8'h00, -1});
    q.push_back('{1'b0, 8'hFF, -1});
    q.push_back('{1'b0, 8'h55, -1});
    frame(1'b0, 8'h00, 1'b1, Div);
    frame(1'b0, 8'hFF, 1'b1, Div);
    frame(1'b0, 8'h55, 1'b1, Div);
    wait_cyc(2 * Div);

    // Reset during bit 4 of 0x81; released while the line is high in bit 7.
    rxd = 1'b0;
    wait_cyc(Div);
    rxd = 1'b1;
    wait_cyc(Div);
    rxd = 1'b0;
    wait_cyc(3 * Div);
    wait_cyc(Div / 2);
    rst = 1'b0;
    #1;
    chk("midreset_data", int'(data), 0);
    chk("midreset_valid", int'(valid), 0);
    chk("midreset_ferr", int'(ferr), 0);
    chk("midreset_busy", int'(busy), 0);
    wait_cyc(Div / 2);
    wait_cyc(2 * Div);
    rxd = 1'b1;
    wait_cyc(Div / 2);
    rst = 1'b1;
    wait_cyc(Div / 2);
    wait_cyc(3 * Div);
    chk("after_reset_idle", int'(busy), 0);
    chk("after_reset_data", int'(data), 0);
    q.push_back('{1'b0, 8'h81, -1});
    frame(1'b0, 8'h81, 1'b1, Div);
    wait_cyc(2 * Div);

    // Full-rate instance with +2% and -2% bit-period skew.
    qf.push_back('{1'b0, 8'h6E, -1});
    frame(1'b1, 8'h6E, 1'b1, 443);
    wait_cyc(500);
    qf.push_back('{1'b0, 8'h6E, -1});
    frame(1'b1, 8'h6E, 1'b1, 425);
    wait_cyc(100);

    for (int i = 0; i < 3000 && (q.size() != 0 || qf.size() != 0); i++) wait_cyc(1);
    chk("queue_drained", q.size(), 0);
    chk("fast_queue_drained", qf.size(), 0);
    chk("valid_pulses", n_valid, 6);
    chk("ferr_pulses", n_ferr, 1);
    chk("fast_valid_pulses", n_valid_f, 2);
    chk("fast_data_final", int'(data_f), 8'h6E);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
